// File: rtl/port_frame_pkg.sv
// Shared types and defaults for the port-2 serial frame receiver.
//   rx_state_e     : receiver FSM states
//   *_DEF          : default parameter values
//   FRAME_BITS     : bits per frame (start + data + parity + stop)
package port_frame_pkg;

   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned OVS_DEF        = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned FRAME_BITS     = DATA_W_DEF + 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

endpackage

// File: rtl/port_frame_rx_if.sv
// Receiver-side bus: serial line in, valid/ready word out, error pulses.
//   slave  : the receiver (drives out_*, flags, busy)
//   master : the environment (drives rx_line, out_ready)
interface port_frame_rx_if #(
   parameter int unsigned DATA_W = 16
);
   logic              rx_line;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              parity_err;
   logic              frame_err;
   logic              overrun;
   logic              busy;

   modport slave (
      input  rx_line, out_ready,
      output out_valid, out_data, parity_err, frame_err, overrun, busy
   );

   modport master (
      output rx_line, out_ready,
      input  out_valid, out_data, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/port_frame_fifo.sv
// Synchronous output FIFO, DATA_W x DEPTH, extra pointer bit for full/empty.
//   push/push_data : write (accepted when not full, or when popping)
//   pop/pop_data   : read head (pop_data is the current head word)
//   full/empty     : occupancy flags
module port_frame_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = ((wr_ptr - rd_ptr) == PW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointers wrap naturally through the extra MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage cleared on reset so the head word reads 0 while empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/port_frame_rx.sv
// Oversampling serial frame receiver: start(0), DATA_W bits LSB first,
// even parity, stop(1). Good words go to an output FIFO; bad or dropped
// words raise a single-cycle parity_err / frame_err / overrun pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : rx_line/out_ready in; out_valid/out_data/flags/busy out
module port_frame_rx
   import port_frame_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned OVS        = OVS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   port_frame_rx_if.slave  bus
);
   localparam int unsigned CW = $clog2(OVS);
   localparam int unsigned BW = $clog2(DATA_W);

   rx_state_e         state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [BW-1:0]     bit_idx, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              perr_q, perr_n;
   logic              stop_wait, wait_n;

   logic              sync1, rxs, rxs_d;
   logic              samp, bnd;
   logic              ferr_c, perr_c, ovr_c, push_c, pop_c;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              parity_err_q, frame_err_q, overrun_q, busy_q;

   // Two-flop synchronizer plus one history flop for start-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= bus.rx_line;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // FSM and datapath state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         perr_q    <= 1'b0;
         stop_wait <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         shreg     <= shreg_n;
         perr_q    <= perr_n;
         stop_wait <= wait_n;
      end
   end

   assign samp  = (cnt == CW'(OVS / 2 - 1));
   assign bnd   = (cnt == CW'(OVS - 1));
   assign pop_c = !fifo_empty && bus.out_ready;

   // Next-state, bit sampling and commit decision
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      shreg_n = shreg;
      perr_n  = perr_q;
      wait_n  = stop_wait;
      ferr_c  = 1'b0;
      perr_c  = 1'b0;
      ovr_c   = 1'b0;
      push_c  = 1'b0;

      if (state != IDLE) cnt_n = bnd ? '0 : cnt + CW'(1);

      unique case (state)
         IDLE: begin
            if (rxs_d && !rxs) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (samp && rxs) begin
               state_n = IDLE;
            end else if (bnd) begin
               state_n = DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (samp) shreg_n = {rxs, shreg[DATA_W-1:1]};
            if (bnd) begin
               if (bit_idx == BW'(DATA_W - 1)) state_n = PARITY;
               else                            bit_n   = bit_idx + BW'(1);
            end
         end
         PARITY: begin
            if (samp) perr_n = rxs ^ (^shreg);
            if (bnd)  state_n = STOP;
         end
         STOP: begin
            // After a bad stop bit, hold here until the line returns idle
            if (stop_wait) begin
               if (rxs) begin
                  state_n = IDLE;
                  wait_n  = 1'b0;
               end
            end else if (samp) begin
               if (!rxs) begin
                  ferr_c = 1'b1;
                  wait_n = 1'b1;
               end else begin
                  // Leave half a bit early so back-to-back starts are seen
                  state_n = IDLE;
                  if (perr_q)                  perr_c = 1'b1;
                  else if (fifo_full && !pop_c) ovr_c = 1'b1;
                  else                         push_c = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n == IDLE) cnt_n = '0;
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         parity_err_q <= perr_c;
         frame_err_q  <= ferr_c;
         overrun_q    <= ovr_c;
         busy_q       <= (state_n != IDLE);
      end
   end

   port_frame_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (shreg),
      .pop       (pop_c),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.out_valid  = !fifo_empty;
   assign bus.out_data   = fifo_data;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_port_frame_rx.sv
// Directed bench for port_frame_rx: drives serial frames on rx_line and
// checks delivered words, error pulses, busy and FIFO back-pressure.
module tb_port_frame_rx;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned OVS    = 8;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   port_frame_rx_if #(.DATA_W(DATA_W)) bus ();

   port_frame_rx #(
      .DATA_W     (DATA_W),
      .OVS        (OVS),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters and captured words, sampled mid-cycle
   int                n_perr = 0, n_ferr = 0, n_ovr = 0, n_valid = 0, n_busy = 0;
   logic [DATA_W-1:0] words [$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.parity_err) n_perr++;
         if (bus.frame_err)  n_ferr++;
         if (bus.overrun)    n_ovr++;
         if (bus.out_valid)  n_valid++;
         if (bus.busy)       n_busy++;
         if (bus.out_valid && bus.out_ready) words.push_back(bus.out_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      bus.rx_line = b;
      tick(OVS);
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] data, input logic flip_par,
                             input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < int'(DATA_W); i++) drive_bit(data[i]);
      drive_bit((^data) ^ flip_par);
      drive_bit(stop);
      bus.rx_line = 1'b1;
      tick(4);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.rx_line = 1'b1;
      bus.out_ready = 1'b1;
      tick(3);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.out_data); end
      checks++; if ({bus.parity_err, bus.frame_err, bus.overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {bus.parity_err, bus.frame_err, bus.overrun}); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      rst_n = 1'b1;
      tick(4);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_good_frame;
      int w0 = words.size(), v0 = n_valid;
      int f0 = n_perr + n_ferr + n_ovr;
      send_frame(16'hA5C3, 1'b0, 1'b1);
      tick(OVS);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid_cycles got=%0d exp=1", n_valid - v0); end
      checks++; if (words.size() - w0 !== 1) begin errors++; $display("FAIL good_word_count got=%0d exp=1", words.size() - w0); end
      else begin
         checks++; if (words[w0] !== 16'hA5C3) begin errors++; $display("FAIL good_data got=%h exp=a5c3", words[w0]); end
      end
      checks++; if (n_perr + n_ferr + n_ovr - f0 !== 0) begin errors++; $display("FAIL good_flags got=%0d exp=0", n_perr + n_ferr + n_ovr - f0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_busy_end got=%b exp=0", bus.busy); end
   endtask

   task automatic test_parity_err;
      int w0 = words.size(), p0 = n_perr, v0 = n_valid;
      send_frame(16'h0001, 1'b1, 1'b1);
      tick(OVS);
      checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_pulses got=%0d exp=1", n_perr - p0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL parity_valid got=%0d exp=0", n_valid - v0); end
      checks++; if (words.size() - w0 !== 0) begin errors++; $display("FAIL parity_words got=%0d exp=0", words.size() - w0); end
   endtask

   task automatic test_frame_err;
      int w0 = words.size(), fe0 = n_ferr, p0 = n_perr;
      send_frame(16'h1234, 1'b0, 1'b0);
      tick(OVS);
      checks++; if (n_ferr - fe0 !== 1) begin errors++; $display("FAIL frame_pulses got=%0d exp=1", n_ferr - fe0); end
      checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL frame_parity got=%0d exp=0", n_perr - p0); end
      checks++; if (words.size() - w0 !== 0) begin errors++; $display("FAIL frame_words got=%0d exp=0", words.size() - w0); end
      send_frame(16'h5678, 1'b0, 1'b1);
      tick(OVS);
      checks++; if (words.size() - w0 !== 1) begin errors++; $display("FAIL frame_next_count got=%0d exp=1", words.size() - w0); end
      else begin
         checks++; if (words[w0] !== 16'h5678) begin errors++; $display("FAIL frame_next_data got=%h exp=5678", words[w0]); end
      end
      checks++; if (n_ferr - fe0 !== 1) begin errors++; $display("FAIL frame_extra_pulse got=%0d exp=1", n_ferr - fe0); end
   endtask

   task automatic test_overrun;
      int w0 = words.size(), o0 = n_ovr;
      int cyc = 0;
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send_frame(16'(k), 1'b0, 1'b1);
      tick(OVS);
      checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - o0); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL ovr_head got=%h exp=0001", bus.out_data); end
      tick(5);
      checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL ovr_head_stable got=%h exp=0001", bus.out_data); end
      bus.out_ready = 1'b1;
      while (words.size() < w0 + 4 && cyc < 20) begin
         tick(1);
         cyc++;
      end
      tick(2);
      checks++; if (words.size() - w0 !== 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", words.size() - w0); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (words[w0 + i] !== 16'(i + 1)) begin errors++; $display("FAIL drain_word%0d got=%h exp=%h", i, words[w0 + i], 16'(i + 1)); end
         end
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_glitch;
      int w0 = words.size(), b0 = n_busy;
      int f0 = n_perr + n_ferr + n_ovr;
      bus.rx_line = 1'b0;
      tick(OVS / 4);
      bus.rx_line = 1'b1;
      tick(2 * OVS);
      checks++; if (n_busy - b0 <= 0) begin errors++; $display("FAIL glitch_busy_seen got=%0d exp>0", n_busy - b0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", bus.busy); end
      checks++; if (n_perr + n_ferr + n_ovr - f0 !== 0) begin errors++; $display("FAIL glitch_flags got=%0d exp=0", n_perr + n_ferr + n_ovr - f0); end
      checks++; if (words.size() - w0 !== 0) begin errors++; $display("FAIL glitch_words got=%0d exp=0", words.size() - w0); end
   endtask

   task automatic test_reset_mid_frame;
      int w0 = words.size();
      int f0 = n_perr + n_ferr + n_ovr;
      drive_bit(1'b0);
      repeat (5) drive_bit(1'b1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
      rst_n = 1'b0;
      bus.rx_line = 1'b1;
      tick(3);
      checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_state got=%b exp=00", {bus.out_valid, bus.busy}); end
      rst_n = 1'b1;
      tick(2 * OVS);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy got=%b exp=0", bus.busy); end
      send_frame(16'h00FF, 1'b0, 1'b1);
      tick(OVS);
      checks++; if (words.size() - w0 !== 1) begin errors++; $display("FAIL mid_word_count got=%0d exp=1", words.size() - w0); end
      else begin
         checks++; if (words[w0] !== 16'h00FF) begin errors++; $display("FAIL mid_data got=%h exp=00ff", words[w0]); end
      end
      checks++; if (n_perr + n_ferr + n_ovr - f0 !== 0) begin errors++; $display("FAIL mid_flags got=%0d exp=0", n_perr + n_ferr + n_ovr - f0); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_err();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
